// File: rtl/mb8_div_pkg.sv
// ---------------------------------------------------------------------------
// mb8_pkg: shared definitions for the mb8_div sequential divider.
//   WIDTH  : divisor / quotient / remainder width (dividend is 2*WIDTH)
//   CNT_W  : width of the iteration counter
//   state_e: divider FSM states
// ---------------------------------------------------------------------------
package mb8_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mb8_div_if.sv
// ---------------------------------------------------------------------------
// mb8_div_if: start/done handshake bundle for mb8_div.
//   master : drives start, dividend, divisor; observes results
//   slave  : the divider side
// ---------------------------------------------------------------------------
interface mb8_div_if;
  import mb8_pkg::*;

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_zero;
  logic                 ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, ovf
  );

endinterface

// File: rtl/mb8_div_step.sv
// ---------------------------------------------------------------------------
// mb8_div_step: one combinational restoring shift-subtract step.
//   prem_i    : current partial remainder (always < divisor_i)
//   bit_i     : next dividend bit shifted in at the bottom
//   divisor_i : divisor
//   prem_o    : next partial remainder
//   qbit_o    : quotient bit produced by this step
// ---------------------------------------------------------------------------
module mb8_div_step
  import mb8_pkg::*;
(
  input  logic [WIDTH-1:0] prem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] prem_o,
  output logic             qbit_o
);

  // The trial value needs WIDTH+1 bits: with a divisor >= 2^(WIDTH-1) the
  // shifted partial remainder can exceed WIDTH bits before subtraction.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  assign trial  = {prem_i, bit_i};
  assign diff   = trial - {1'b0, divisor_i};
  assign qbit_o = (trial >= {1'b0, divisor_i});
  // Since prem_i < divisor_i, a successful subtraction always fits WIDTH bits.
  assign prem_o = qbit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/mb8_div.sv
// ---------------------------------------------------------------------------
// mb8_div: sequential unsigned 2W/W divider, one restoring step per cycle.
//   CLK : clock, rising edge
//   RST : synchronous active-low reset
//   bus : mb8_div_if.slave (start/dividend/divisor in; busy/done/quotient/
//         remainder/div_zero/ovf out)
// Normal divisions complete WIDTH cycles after the accepting edge; a zero
// divisor or an overflowing quotient completes one cycle after it.
// Optional macro MB8_DIV_REGOUT_EN adds an output register stage on done
// and the result signals (one extra cycle of latency, busy held through it).
// ---------------------------------------------------------------------------
module mb8_div
  import mb8_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  mb8_div_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   prem_q, prem_d;     // partial remainder
  logic [WIDTH-1:0]   sreg_q, sreg_d;     // dividend bits out, quotient bits in
  logic [WIDTH-1:0]   dvs_q, dvs_d;       // captured divisor
  logic               fdz_q, fdz_d;       // pending fast-path div_zero
  logic               fovf_q, fovf_d;     // pending fast-path overflow
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   step_prem;
  logic               step_qbit;
  logic               fast;

  // Fast-path results spend one CALC cycle with no iterations so that
  // done appears one cycle after acceptance, with busy kept low.
  assign fast = fdz_q | fovf_q;

  mb8_div_step u_step (
    .prem_i    (prem_q),
    .bit_i     (sreg_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .prem_o    (step_prem),
    .qbit_o    (step_qbit)
  );

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    sreg_d  = sreg_q;
    dvs_d   = dvs_q;
    fdz_d   = fdz_q;
    fovf_d  = fovf_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = '0;
          dvs_d   = bus.divisor;
          sreg_d  = bus.dividend[WIDTH-1:0];
          prem_d  = bus.dividend[2*WIDTH-1:WIDTH];
          fdz_d   = 1'b0;
          fovf_d  = 1'b0;
          if (bus.divisor == '0) begin
            fdz_d  = 1'b1;
            prem_d = bus.dividend[WIDTH-1:0];
          end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
            // Upper half >= divisor means the quotient needs > WIDTH bits.
            fovf_d = 1'b1;
            prem_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (fast) begin
          state_d = DONE;
          quot_d  = '1;
          rem_d   = prem_q;
          dz_d    = fdz_q;
          ovf_d   = fovf_q;
        end else begin
          prem_d = step_prem;
          sreg_d = {sreg_q[WIDTH-2:0], step_qbit};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            quot_d  = {sreg_q[WIDTH-2:0], step_qbit};
            rem_d   = step_prem;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fdz_q   <= 1'b0;
      fovf_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fdz_q   <= fdz_d;
      fovf_q  <= fovf_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: working datapath registers are always loaded before use on an
  // accepted start, so they carry no reset.
  always_ff @(posedge CLK) begin
    prem_q <= prem_d;
    sreg_q <= sreg_d;
    dvs_q  <= dvs_d;
  end

`ifdef MB8_DIV_REGOUT_EN
  logic             done_r;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic             dz_r, ovf_r;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      done_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
      dz_r   <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= (state_q == DONE);
      quot_r <= quot_q;
      rem_r  <= rem_q;
      dz_r   <= dz_q;
      ovf_r  <= ovf_q;
    end
  end

  assign bus.busy      = !fast && ((state_q == CALC) || (state_q == DONE));
  assign bus.done      = done_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign bus.div_zero  = dz_r;
  assign bus.ovf       = ovf_r;
`else
  assign bus.busy      = !fast && (state_q == CALC);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.ovf       = ovf_q;
`endif

endmodule
